// File: rtl/alu_7seg_scheduler_pkg.sv
// Shared opcode and FSM encodings for the ALU/7-seg display scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_7seg_scheduler_if.sv
// Requester/datapath bundle of the scheduler; result ports exist only when
// ALU_SCHED_RESULT_EN is defined.
interface alu_7seg_scheduler_if #(
  parameter int N    = 4,
  parameter int NREQ = 2
) ();
  import alu_sched_pkg::*;

  // Handshake: a requester holds req[i] high (with stable fields) until it
  // sees gnt[i], a one-cycle pulse; dropping req[i] earlier withdraws it.
  logic [NREQ-1:0]         req;
  logic [NREQ*N-1:0]       a_in;
  logic [NREQ*N-1:0]       b_in;
  logic [NREQ*2-1:0]       op_in;
  logic [NREQ-1:0]         gnt;
  logic                    done;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;
  logic [N-1:0]            alu_a;
  logic [N-1:0]            alu_b;
  logic [1:0]              alu_op;
  logic                    alu_enable;
  state_e                  state;
`ifdef ALU_SCHED_RESULT_EN
  logic [N-1:0]            result;
  logic                    result_valid;
`endif

`ifdef ALU_SCHED_RESULT_EN
  modport master (output req, a_in, b_in, op_in,
                  input gnt, done, owner, busy, alu_a, alu_b, alu_op,
                  alu_enable, state, result, result_valid);
  modport slave  (input req, a_in, b_in, op_in,
                  output gnt, done, owner, busy, alu_a, alu_b, alu_op,
                  alu_enable, state, result, result_valid);
`else
  modport master (output req, a_in, b_in, op_in,
                  input gnt, done, owner, busy, alu_a, alu_b, alu_op,
                  alu_enable, state);
  modport slave  (input req, a_in, b_in, op_in,
                  output gnt, done, owner, busy, alu_a, alu_b, alu_op,
                  alu_enable, state);
`endif

endinterface

// File: rtl/alu_7seg_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid_o && req_i[wrap_idx(ptr_i, k)]) begin
        valid_o                     = 1'b1;
        idx_o                       = wrap_idx(ptr_i, k);
        gnt_oh_o[wrap_idx(ptr_i, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_7seg_scheduler.sv
// Round-robin scheduler sharing one ALU/7-seg datapath among NREQ requesters.
// Optional ALU_SCHED_RESULT_EN adds a registered result/result_valid pair.
module alu_7seg_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N           = 4,
  parameter int NREQ        = 2,
  parameter int HOLD_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst,
  alu_7seg_scheduler_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_e          state_q;
  logic [IW-1:0]   ptr_q, ptr_d, owner_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    alu_a_q, alu_b_q;
  logic [1:0]      alu_op_q;
  logic            en_q, done_q, busy_q;
  logic [NREQ-1:0] gnt_q;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic [N-1:0]    win_a, win_b;
  logic [1:0]      win_op;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .gnt_oh_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  assign win_a  = bus.a_in[int'(win_idx)*N +: N];
  assign win_b  = bus.b_in[int'(win_idx)*N +: N];
  assign win_op = bus.op_in[int'(win_idx)*2 +: 2];
  assign ptr_d  = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef ALU_SCHED_RESULT_EN
  logic [N-1:0] result_q, result_d;

  always_comb begin
    result_d = '0;
    case (win_op)
      OP_ADD:  result_d = win_a + win_b;
      OP_OR:   result_d = win_a | win_b;
      OP_SUB:  result_d = win_a - win_b;
      default: result_d = win_a ^ win_b;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      en_q     <= 1'b0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALU_SCHED_RESULT_EN
      result_q <= '0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q  <= ST_SHOW;
            gnt_q    <= win_oh;
            owner_q  <= win_idx;
            ptr_q    <= ptr_d;
            cnt_q    <= CW'(HOLD_CYCLES - 1);
            alu_a_q  <= win_a;
            alu_b_q  <= win_b;
            alu_op_q <= win_op;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
`ifdef ALU_SCHED_RESULT_EN
            result_q <= result_d;
`endif
          end
        end
        ST_SHOW: begin
          // Count reaches zero on the last enabled cycle; done lands in GAP.
          if (cnt_q == '0) begin
            state_q <= ST_GAP;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_enable = en_q;
  assign bus.state      = state_q;
`ifdef ALU_SCHED_RESULT_EN
  assign bus.result       = result_q;
  assign bus.result_valid = en_q;
`endif

endmodule

// File: tb/tb_alu_7seg_scheduler.sv
// Bench for alu_7seg_scheduler: timeline reference model plus directed scenarios.
module tb_alu_7seg_scheduler;

  localparam int N    = 4;
  localparam int NREQ = 2;
  localparam int H    = 8;
  localparam int IW   = $clog2(NREQ);
  localparam int AW   = NREQ * N;
  localparam int OW   = NREQ * 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_7seg_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

  alu_7seg_scheduler #(.N(N), .NREQ(NREQ), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: time elapsed since the last grant (-1 = idle).
  int         m_since = -1;
  int         m_ptr = 0;
  int         m_owner = 0;
  int         m_a = 0, m_b = 0, m_op = 0, m_res = 0;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_since = -1; m_ptr = 0; m_owner = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0;
      model_valid = 1'b1;
    end else if (m_since < 0) begin
      if (bus.req != '0) begin
        int w;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_owner = w;
        m_ptr   = (w + 1) % NREQ;
        m_a     = int'(bus.a_in[w*N +: N]);
        m_b     = int'(bus.b_in[w*N +: N]);
        m_op    = int'(bus.op_in[w*2 +: 2]);
        case (m_op)
          0: m_res = (m_a + m_b) % (1 << N);
          1: m_res = m_a | m_b;
          2: m_res = (m_a - m_b + (1 << N)) % (1 << N);
          default: m_res = m_a ^ m_b;
        endcase
        m_since = 0;
      end
    end else begin
      m_since++;
      if (m_since > H) m_since = -1;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (model_valid) begin
      check("cmp_enable", 32'(bus.alu_enable), 32'(m_since >= 0 && m_since < H));
      check("cmp_done",   32'(bus.done),       32'(m_since == H));
      check("cmp_busy",   32'(bus.busy),       32'(m_since >= 0));
      check("cmp_gnt",    32'(bus.gnt),        (m_since == 0) ? (32'd1 << m_owner) : 32'd0);
      check("cmp_owner",  32'(bus.owner),      32'(m_owner));
      check("cmp_alu_a",  32'(bus.alu_a),      32'(m_a));
      check("cmp_alu_b",  32'(bus.alu_b),      32'(m_b));
      check("cmp_alu_op", 32'(bus.alu_op),     32'(m_op));
`ifdef ALU_SCHED_RESULT_EN
      check("cmp_result", 32'(bus.result),       32'(m_res));
      check("cmp_rvalid", 32'(bus.result_valid), 32'(m_since >= 0 && m_since < H));
`endif
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output int w, output int lat);
    w = -1;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) w = i;
        lat = k;
        break;
      end
    end
    if (w < 0) check("gnt_timeout", 32'd1, 32'd0);
  endtask

  // Walk the display window from the grant cycle; returns offset of done.
  task automatic run_window(output int done_at, output int en_cnt, input logic [N-1:0] a_exp);
    en_cnt = 0;
    done_at = -1;
    for (int k = 0; k < 30; k++) begin
      if (bus.alu_enable) begin
        en_cnt++;
        check("window_alu_a", 32'(bus.alu_a), 32'(a_exp));
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [IW-1:0] exp_q[$];

  initial begin
    int w, lat, done_at, en_cnt, prev_stamp;
    logic seen;
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.op_in = '0;

    // reset state
    do_reset();
    check("rst_enable", 32'(bus.alu_enable), 32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_gnt",    32'(bus.gnt),        32'd0);
    check("rst_owner",  32'(bus.owner),      32'd0);
    check("rst_alu_a",  32'(bus.alu_a),      32'd0);
    check("rst_alu_op", 32'(bus.alu_op),     32'd0);

    // single request: 1 + 2 add
    bus.req = 2'b01; bus.a_in = 8'h01; bus.b_in = 8'h02; bus.op_in = 4'b0000;
    wait_gnt(w, lat);
    bus.req = '0;
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_lat", 32'(lat), 32'd0);
`ifdef ALU_SCHED_RESULT_EN
    check("single_result", 32'(bus.result), 32'h3);
`endif
    run_window(done_at, en_cnt, 4'h1);
    check("single_en_cnt",  32'(en_cnt),  32'd8);
    check("single_done_at", 32'(done_at), 32'd8);

    // both held: order 0,1,0,1 with 10-cycle spacing
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    bus.req = 2'b11;
    prev_stamp = 0;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(w, lat);
      check("rr_order", 32'(w), 32'(exp_q.pop_front()));
      if (g > 0) check("rr_spacing", 32'(cyc - prev_stamp), 32'd10);
      prev_stamp = cyc;
    end
    bus.req = '0;

    // operand change during SHOW
    do_reset();
    bus.req = 2'b10; bus.a_in = 8'hA0; bus.b_in = 8'h40; bus.op_in = 4'b1000;
    wait_gnt(w, lat);
    bus.req = '0;
    bus.a_in = 8'hF0;
    check("opchg_owner", 32'(w), 32'd1);
`ifdef ALU_SCHED_RESULT_EN
    check("opchg_result", 32'(bus.result), 32'h6);
`endif
    run_window(done_at, en_cnt, 4'hA);
    check("opchg_en_cnt", 32'(en_cnt), 32'd8);

    // withdrawn request during requester 0's window
    do_reset();
    bus.req = 2'b01;
    wait_gnt(w, lat);
    bus.req = '0;
    @(negedge clk); @(negedge clk);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt[1]) seen = 1'b1;
    end
    check("withdraw_no_gnt", 32'(seen), 32'd0);
    check("withdraw_idle",   32'(bus.busy), 32'd0);

    // wrap arithmetic
    do_reset();
    bus.req = 2'b01; bus.a_in = 8'h0F; bus.b_in = 8'h01; bus.op_in = 4'b0000;
    wait_gnt(w, lat);
    bus.req = '0;
    check("wrap_add_a", 32'(bus.alu_a), 32'hF);
`ifdef ALU_SCHED_RESULT_EN
    check("wrap_add_result", 32'(bus.result), 32'h0);
`endif
    run_window(done_at, en_cnt, 4'hF);
    @(negedge clk);
    bus.req = 2'b01; bus.a_in = 8'h00; bus.b_in = 8'h01; bus.op_in = 4'b0010;
    wait_gnt(w, lat);
    bus.req = '0;
    check("wrap_sub_op", 32'(bus.alu_op), 32'h2);
`ifdef ALU_SCHED_RESULT_EN
    check("wrap_sub_result", 32'(bus.result), 32'hF);
`endif
    run_window(done_at, en_cnt, 4'h0);

    // reset mid-SHOW in the 3rd enabled cycle
    do_reset();
    bus.req = 2'b01; bus.a_in = 8'h05; bus.b_in = 8'h03; bus.op_in = 4'b0011;
    wait_gnt(w, lat);
    bus.req = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_enable", 32'(bus.alu_enable), 32'd0);
    check("midrst_busy",   32'(bus.busy),       32'd0);
    check("midrst_alu_a",  32'(bus.alu_a),      32'd0);
    check("midrst_alu_b",  32'(bus.alu_b),      32'd0);
    check("midrst_alu_op", 32'(bus.alu_op),     32'd0);
    check("midrst_owner",  32'(bus.owner),      32'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // randomized requesters, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if (bus.gnt[i]) bus.req[i] = ($urandom_range(0, 1) == 0);
          else if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        bus.a_in  = AW'($urandom);
        bus.b_in  = AW'($urandom);
        bus.op_in = OW'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_7seg_scheduler.md
# alu_7seg_scheduler

Round-robin scheduler that shares one 4-bit ALU/seven-segment display datapath between NREQ independent requesters. Each requester presents operands and an opcode with a request. The scheduler grants one requester at a time, loads its operation into the datapath, and holds the display enabled for HOLD_CYCLES clocks. It then blanks the display for one cycle and moves to the next requester. It sits directly in front of the ALU/display block and drives all of that block's inputs.

## Interface
- N, 4: operand width, passed through to the ALU datapath.
- NREQ, 2: number of requesters; legal range 2..8.
- HOLD_CYCLES, 8: clocks the display stays enabled per granted operation; must be ≥1.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*N  packed A operands; requester i uses bits [i*N +: N].
- b_in  in  NREQ*N  packed B operands, same packing.
- op_in  in  NREQ*2  packed opcodes: 00 add, 01 OR, 10 subtract, 11 XOR.
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- done  out  1  one-cycle pulse when the granted operation's display window ends.
- owner  out  $clog2(NREQ)  index of the current/last granted requester.
- busy  out  1  high whenever the state is not IDLE.
- alu_a, alu_b  out  N  operands to the datapath.
- alu_op  out  2  opcode to the datapath.
- alu_enable  out  1  display enable to the datapath.

## Operation
- States:
  - IDLE: alu_enable=0. If any req is high, arbitrate and go to SHOW on the next edge; otherwise stay.
  - SHOW: alu_enable=1. Count down; at count 0, go to GAP.
  - GAP: alu_enable=0 and done=1 for exactly this cycle. Unconditionally go to IDLE next.
- Arbitration:
  - The winner is the first i with req[i]=1, searching from ptr upward and wrapping at NREQ-1 to 0.
  - On the IDLE→SHOW edge, all of the following register together:
    - alu_a/alu_b/alu_op take the winner's fields.
    - gnt becomes onehot(winner) for one cycle.
    - owner becomes winner.
    - ptr becomes (winner+1) mod NREQ.
    - cnt becomes HOLD_CYCLES-1.
- Operands are sampled only at grant. Input changes during SHOW/GAP have no effect.
- alu_a/alu_b/alu_op hold their last values outside SHOW; only alu_enable blanks the display.
- Requester protocol:
  - A requester holds req until it sees its gnt bit. Dropping req before the grant withdraws the request.
  - req still high on return to IDLE counts as a new request, subject to round-robin.
- Simultaneous requests: resolved purely by ptr; no fixed priority, no starvation. Each requester waits at most NREQ-1 operations.
- Reset (at any time, including mid-SHOW): next edge forces state=IDLE, ptr=0, cnt=0, owner=0, alu_a=alu_b=0, alu_op=00, alu_enable=0, gnt=0, done=0, busy=0.

## Timing
- Latency from req to gnt/alu_enable: 1 clock, provided IDLE sees req.
- alu_enable is high for exactly HOLD_CYCLES consecutive cycles per grant.
- done fires the cycle immediately after the last enabled cycle.
- Minimum grant-to-grant spacing: HOLD_CYCLES+2 cycles (SHOW + GAP + IDLE).
- gnt and the first alu_enable=1 cycle coincide.
- All outputs are registered; there is no combinational path from req/a_in/b_in/op_in to any output.

## Configuration
- ALU_SCHED_RESULT_EN defined:
  - Adds ports `result` (out, N) and `result_valid` (out, 1).
  - result is registered at grant from the latched operands:
    - add/sub: modulo 2^N, carry/borrow discarded.
    - OR, XOR: bitwise.
  - result_valid equals alu_enable. Both reset to 0.
- Macro undefined: ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package alu_sched_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_OR=2'b01, OP_SUB=2'b10, OP_XOR=2'b11;
  - the state encoding IDLE/SHOW/GAP.
- One sub-module, rr_arbiter (inputs req and ptr; output one-hot winner and index), is purely combinational. The FSM, counter and registers stay in alu_7seg_scheduler.

## Test plan
- Reset mid-SHOW: grant requester 0, assert rst in the 3rd enabled cycle → next edge alu_enable=0, busy=0, alu_a/alu_b/alu_op=0, owner=0; no done pulse.
- Single request, HOLD_CYCLES=8, NREQ=2: req[0]=1 with A=0001, B=0010, op=00 → gnt=01 one cycle later; alu_enable high 8 cycles; done on cycle 9; result=0011 with macro.
- Both requesters held high continuously, ptr=0 after reset → grant order 0,1,0,1; gnt pulses exactly 10 cycles apart.
- Operand change during SHOW: requester 1 granted with A=1010, B=0100, op=10, then A changed to 1111 → alu_a stays 1010 for the whole window; result=0110.
- Withdrawn request: req[1] pulsed for 1 cycle during requester 0's SHOW → requester 1 is never granted; return to IDLE with busy=0.
- Wrap arithmetic with macro: A=1111, B=0001, op=00 → result=0000. A=0000, B=0001, op=10 → result=1111.
